axis_testpattern_checker: RTL and testbench

- AXI-Stream slave that sits directly downstream of axis_testpattern_generator and consumes its counter pattern.
- Locks onto the incoming sequence START, START+INCR, ... up to END, then wraps back to START, and checks every accepted beat against the expected value.
- Reports lock state, mismatches, stalls and beat/wrap statistics.
- Can throttle tready periodically to exercise upstream backpressure handling.

---
 rtl/axis_testpattern_checker.sv | 187 ++++++++++++++++++
 tb/tb_axis_testpattern_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream checker for the counter pattern of axis_testpattern_generator.
// Locks onto START..END, reports mismatches, stalls and beat/wrap statistics.
module axis_testpattern_checker #(
    parameter int unsigned S00_AXIS_TDATA_WIDTH = 24,
    parameter int unsigned COUNTER_START        = 1,
    parameter int unsigned COUNTER_END          = 10,
    parameter int unsigned COUNTER_INCR         = 1,
    parameter int unsigned READY_PERIOD         = 0,
    parameter int unsigned TIMEOUT_CYCLES       = 64
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_areset,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic                            locked,
    output logic                            error_pulse,
    output logic                            stall_error,
    output logic [15:0]                     error_count,
    output logic [31:0]                     beat_count,
    output logic [15:0]                     wrap_count,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] last_expected,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] last_received
);
    localparam int unsigned W  = S00_AXIS_TDATA_WIDTH;
    localparam int unsigned WX = W + 1;

    localparam logic [WX-1:0] START_X  = WX'(COUNTER_START);
    localparam logic [WX-1:0] END_X    = WX'(COUNTER_END);
    localparam logic [WX-1:0] INCR_X   = WX'(COUNTER_INCR);
    localparam logic [W-1:0]  START_W  = W'(COUNTER_START);
    localparam logic          THR_EN   = (READY_PERIOD > 1);
    localparam logic [15:0]   THR_LAST = (READY_PERIOD > 1) ? 16'(READY_PERIOD - 1) : 16'd0;
    localparam logic          WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0]   WD_LIMIT = 32'(TIMEOUT_CYCLES);

    localparam logic [0:0] SYNC   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] exp_q, exp_d;
    logic         wpend_q, wpend_d;
    logic [15:0]  thr_q, thr_d;
    logic [31:0]  wd_q, wd_d;
    logic         stall_q, stall_d;
    logic         perr_q, perr_d;
    logic [15:0]  errc_q, errc_d;
    logic [31:0]  beat_q, beat_d;
    logic [15:0]  wrap_q, wrap_d;
    logic [W-1:0] lexp_q, lexp_d;
    logic [W-1:0] lrcv_q, lrcv_d;

    logic          throttle_low;
    logic          beat;
    logic          tdata_member;
    logic [WX-1:0] nx_sum;
    logic          nx_wrap;
    logic [W-1:0]  nx_val;

    function automatic logic is_member(input logic [W-1:0] x);
        logic [WX-1:0] xx;
        xx = {1'b0, x};
        return (xx >= START_X) && (xx <= END_X) && (((xx - START_X) % INCR_X) == '0);
    endfunction

    // tready comes from flops and enable only; no path from tvalid.
    assign throttle_low  = THR_EN && (thr_q == THR_LAST);
    assign s_axis_tready = enable & ~throttle_low & ~s_axis_areset;
    assign beat          = s_axis_tvalid & s_axis_tready;

    assign tdata_member = is_member(s_axis_tdata);
    assign nx_sum       = {1'b0, s_axis_tdata} + INCR_X;
    assign nx_wrap      = nx_sum > END_X;
    assign nx_val       = nx_wrap ? START_W : nx_sum[W-1:0];

    always_comb begin
        thr_d = thr_q;
        if (enable) begin
            thr_d = (throttle_low || !THR_EN) ? 16'd0 : thr_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wpend_d = wpend_q;
        wd_d    = wd_q;
        stall_d = stall_q;
        perr_d  = 1'b0;
        errc_d  = errc_q;
        beat_d  = beat_q;
        wrap_d  = wrap_q;
        lexp_d  = lexp_q;
        lrcv_d  = lrcv_q;
        if (clear) begin
            state_d = SYNC;
            wpend_d = 1'b0;
            wd_d    = '0;
            stall_d = 1'b0;
            errc_d  = '0;
            beat_d  = '0;
            wrap_d  = '0;
            lexp_d  = '0;
            lrcv_d  = '0;
        end else if (beat) begin
            beat_d = beat_q + 32'd1;
            wd_d   = '0;
            if (state_q == SYNC) begin
                if (tdata_member) begin
                    state_d = LOCKED;
                    exp_d   = nx_val;
                    wpend_d = nx_wrap;
                end
            end else if (s_axis_tdata == exp_q) begin
                // A wrap is counted when the START beat that follows END arrives.
                if (wpend_q) begin
                    wrap_d = wrap_q + 16'd1;
                end
                exp_d   = nx_val;
                wpend_d = nx_wrap;
            end else begin
                perr_d = 1'b1;
                if (errc_q != 16'hFFFF) begin
                    errc_d = errc_q + 16'd1;
                end
                lexp_d = exp_q;
                lrcv_d = s_axis_tdata;
                if (tdata_member) begin
                    exp_d   = nx_val;
                    wpend_d = nx_wrap;
                end else begin
                    state_d = SYNC;
                end
            end
        end else if (WD_EN && (state_q == LOCKED) && s_axis_tready) begin
            if (wd_q + 32'd1 >= WD_LIMIT) begin
                stall_d = 1'b1;
                state_d = SYNC;
                wd_d    = '0;
            end else begin
                wd_d = wd_q + 32'd1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q <= SYNC;
            exp_q   <= '0;
            wpend_q <= 1'b0;
            thr_q   <= '0;
            wd_q    <= '0;
            stall_q <= 1'b0;
            perr_q  <= 1'b0;
            errc_q  <= '0;
            beat_q  <= '0;
            wrap_q  <= '0;
            lexp_q  <= '0;
            lrcv_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            wpend_q <= wpend_d;
            thr_q   <= thr_d;
            wd_q    <= wd_d;
            stall_q <= stall_d;
            perr_q  <= perr_d;
            errc_q  <= errc_d;
            beat_q  <= beat_d;
            wrap_q  <= wrap_d;
            lexp_q  <= lexp_d;
            lrcv_q  <= lrcv_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign error_pulse   = perr_q;
    assign stall_error   = stall_q;
    assign error_count   = errc_q;
    assign beat_count    = beat_q;
    assign wrap_count    = wrap_q;
    assign last_expected = lexp_q;
    assign last_received = lrcv_q;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Bench for axis_testpattern_checker: sequence-index model compared every cycle on
// instance A, plus a backpressure run against a throttled instance B.
`timescale 1ns/1ps
module tb_axis_testpattern_checker;
    localparam int S  = 1;
    localparam int E  = 10;
    localparam int I  = 1;
    localparam int N  = (E - S) / I + 1;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en_a, clr_a, vld_a, rdy_a, lk_a, ep_a, st_a;
    logic [23:0] dat_a, le_a, lr_a;
    logic [15:0] ec_a, wc_a;
    logic [31:0] bc_a;
    logic        en_b, clr_b, vld_b, rdy_b, lk_b, ep_b, st_b;
    logic [23:0] dat_b, le_b, lr_b;
    logic [15:0] ec_b, wc_b;
    logic [31:0] bc_b;

    axis_testpattern_checker #(
        .S00_AXIS_TDATA_WIDTH(24), .COUNTER_START(S), .COUNTER_END(E), .COUNTER_INCR(I),
        .READY_PERIOD(0), .TIMEOUT_CYCLES(TO)
    ) dut_a (
        .s_axis_aclk(clk), .s_axis_areset(rst), .enable(en_a), .clear(clr_a),
        .s_axis_tdata(dat_a), .s_axis_tvalid(vld_a), .s_axis_tready(rdy_a),
        .locked(lk_a), .error_pulse(ep_a), .stall_error(st_a), .error_count(ec_a),
        .beat_count(bc_a), .wrap_count(wc_a), .last_expected(le_a), .last_received(lr_a)
    );

    axis_testpattern_checker #(
        .S00_AXIS_TDATA_WIDTH(24), .COUNTER_START(S), .COUNTER_END(E), .COUNTER_INCR(I),
        .READY_PERIOD(4), .TIMEOUT_CYCLES(TO)
    ) dut_b (
        .s_axis_aclk(clk), .s_axis_areset(rst), .enable(en_b), .clear(clr_b),
        .s_axis_tdata(dat_b), .s_axis_tvalid(vld_b), .s_axis_tready(rdy_b),
        .locked(lk_b), .error_pulse(ep_b), .stall_error(st_b), .error_count(ec_b),
        .beat_count(bc_b), .wrap_count(wc_b), .last_expected(le_b), .last_received(lr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected value tracked as an index into the sequence S, S+I, ... (N members).
    bit          m_lk, m_pend, m_ep, m_st;
    int          m_pos, m_idle, m_ec, m_wc, md;
    int unsigned m_bc;
    bit [23:0]   m_le, m_lr;

    function automatic bit member(input int x);
        return (x >= S) && (x <= E) && ((x - S) % I == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lk = 0; m_pend = 0; m_ep = 0; m_st = 0; m_pos = 0; m_idle = 0;
            m_ec = 0; m_wc = 0; m_bc = 0; m_le = '0; m_lr = '0;
        end else begin
            md   = int'(dat_a);
            m_ep = 0;
            if (clr_a) begin
                m_lk = 0; m_pend = 0; m_st = 0; m_idle = 0;
                m_ec = 0; m_wc = 0; m_bc = 0; m_le = '0; m_lr = '0;
            end else if (vld_a && en_a) begin
                m_bc++;
                m_idle = 0;
                if (m_lk && md != S + m_pos * I) begin
                    m_ep = 1;
                    if (m_ec < 65535) m_ec++;
                    m_le = 24'(S + m_pos * I);
                    m_lr = dat_a;
                end else if (m_lk && m_pend) begin
                    m_wc = (m_wc + 1) % 65536;
                end
                if (member(md)) begin
                    m_lk   = 1;
                    m_pend = ((md - S) / I == N - 1);
                    m_pos  = ((md - S) / I + 1) % N;
                end else begin
                    m_lk = 0;
                end
            end else if (m_lk && en_a) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_st = 1; m_lk = 0; m_idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("a_tready", rdy_a, en_a && !rst);
        check("a_locked", lk_a, m_lk);
        check("a_error_pulse", ep_a, m_ep);
        check("a_stall", st_a, m_st);
        check("a_error_count", ec_a, m_ec);
        check("a_beat_count", bc_a, m_bc);
        check("a_wrap_count", wc_a, m_wc);
        check("a_last_expected", le_a, m_le);
        check("a_last_received", lr_a, m_lr);
    end

    task automatic send(input logic [23:0] v);
        vld_a = 1'b1;
        dat_a = v;
        @(posedge clk);
        #1;
        vld_a = 1'b0;
    endtask

    task automatic idle(input int n);
        vld_a = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int acc, cyc, bcnt, g;
    bit take;

    initial begin
        en_a = 0; clr_a = 0; vld_a = 0; dat_a = '0;
        en_b = 0; clr_b = 0; vld_b = 0; dat_b = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_beat_count", bc_a, 0);
        check("reset_locked", lk_a, 0);
        check("reset_tready", rdy_a, 0);
        check("reset_b_tready", rdy_b, 0);
        rst  = 1'b0;
        en_a = 1'b1;

        // Clean stream 1..10 three times, valid every other cycle.
        for (int r = 0; r < 3; r++) begin
            for (int v = S; v <= E; v += I) begin
                send(24'(v));
                if (r == 0 && v == S) check("lock_after_first", lk_a, 1);
                idle(1);
            end
        end
        check("clean_beats", bc_a, 30);
        check("clean_wraps", wc_a, 2);
        check("clean_errors", ec_a, 0);
        check("clean_locked", lk_a, 1);

        // 4,7,8: one mismatch, then resync.
        send(1); send(2); send(3); send(4); send(7);
        check("inj_pulse", ep_a, 1);
        check("inj_last_exp", le_a, 5);
        check("inj_last_rcv", lr_a, 7);
        check("inj_errors", ec_a, 1);
        idle(1);
        check("inj_pulse_one_cycle", ep_a, 0);
        send(8);
        check("inj_next_ok", ec_a, 1);

        // Out-of-range beat drops lock; 1,2,3 relocks.
        send(24'h00FFFF);
        check("oor_errors", ec_a, 2);
        check("oor_locked", lk_a, 0);
        check("oor_last_exp", le_a, 9);
        check("oor_last_rcv", lr_a, 24'h00FFFF);
        send(1);
        check("relock", lk_a, 1);
        send(2); send(3);
        check("relock_no_error", ec_a, 2);

        // Watchdog: 64 ready cycles with no beat.
        idle(TO - 1);
        check("wd_before_locked", lk_a, 1);
        check("wd_before_stall", st_a, 0);
        idle(1);
        check("wd_stall", st_a, 1);
        check("wd_unlocked", lk_a, 0);

        // Clear, relock, then hold with enable low.
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        check("clr_beats", bc_a, 0);
        check("clr_stall", st_a, 0);
        check("clr_errors", ec_a, 0);
        check("clr_last_rcv", lr_a, 0);
        send(1); send(2);
        en_a  = 1'b0;
        vld_a = 1'b1;
        dat_a = 24'd99;
        repeat (200) begin
            @(posedge clk);
            #1;
        end
        check("hold_stall", st_a, 0);
        check("hold_locked", lk_a, 1);
        check("hold_beats", bc_a, 2);
        en_a  = 1'b1;
        dat_a = 24'd3;
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        check("resume_beats", bc_a, 3);
        check("resume_errors", ec_a, 0);
        send(7);
        check("resume_mis_errors", ec_a, 1);
        check("resume_mis_exp", le_a, 4);

        // Throttled instance against a holding source.
        en_a  = 1'b0;
        g     = S;
        dat_b = 24'(g);
        vld_b = 1'b1;
        en_b  = 1'b1;
        acc   = 0;
        cyc   = 0;
        bcnt  = 0;
        while (acc < 100 && cyc < 1000) begin
            @(negedge clk);
            check("b_tready", rdy_b, bcnt != 3);
            take = rdy_b;
            @(posedge clk);
            #1;
            bcnt = (bcnt + 1) % 4;
            cyc++;
            if (take) begin
                acc++;
                g     = (g + I > E) ? S : g + I;
                dat_b = 24'(g);
            end
        end
        vld_b = 1'b0;
        en_b  = 1'b0;
        check("b_accepted", acc, 100);
        @(posedge clk);
        #1;
        check("b_beats", bc_b, 100);
        check("b_errors", ec_b, 0);
        check("b_wraps", wc_b, 9);
        check("b_locked", lk_b, 1);
        check("b_stall", st_b, 0);

        // Async reset in the middle of a pending beat, then clear with a beat.
        en_a  = 1'b1;
        vld_a = 1'b1;
        dat_a = 24'd8;
        #2 rst = 1'b1;
        #1;
        check("arst_beats", bc_a, 0);
        check("arst_errors", ec_a, 0);
        check("arst_last_exp", le_a, 0);
        check("arst_last_rcv", lr_a, 0);
        check("arst_tready", rdy_a, 0);
        check("arst_locked", lk_a, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        clr_a = 1'b1;
        dat_a = 24'd1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        vld_a = 1'b0;
        check("clr_beat_dropped", bc_a, 0);
        check("clr_beat_no_lock", lk_a, 0);
        send(1); send(2);
        check("post_clr_beats", bc_a, 2);
        check("post_clr_locked", lk_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
